// File: rtl/mario_pkg.sv
// ============================================================================
//  Module      : mario_pkg
//  Description : Object RAM layout, scan FSM encoding and the shared hit test
//                used by the object scanner and the sprite line renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mario_pkg;

  // Object RAM image at $7000, filled by the sprite DMA.
  localparam int OBJ_BASE      = 'h7000;
  localparam int OBJ_RAM_BYTES = 'h180;
  localparam int OBJ_ENTRIES   = OBJ_RAM_BYTES / 4;
  localparam int OBJ_H_DEFAULT = 16;

  localparam logic [1:0] OFF_Y    = 2'd0;
  localparam logic [1:0] OFF_CODE = 2'd1;
  localparam logic [1:0] OFF_ATTR = 2'd2;
  localparam logic [1:0] OFF_X    = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH_Y  = 4'd1,
    ST_CHECK    = 4'd2,
    ST_FETCH_B1 = 4'd3,
    ST_FETCH_B2 = 4'd4,
    ST_FETCH_B3 = 4'd5,
    ST_EMIT     = 4'd6,
    ST_NEXT     = 4'd7,
    ST_DONE     = 4'd8
  } scan_state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
  } obj_hit_t;

  // Y == 0 marks an empty slot; the 8-bit wrap lets objects straddle line 0.
  function automatic obj_hit_t obj_hit(input logic [7:0] line,
                                       input logic [7:0] y,
                                       input logic [8:0] height);
    logic [7:0] diff;
    obj_hit_t   res;
    diff    = line - y;
    res.hit = (y != 8'd0) && ({1'b0, diff} < height);
    res.row = diff[3:0];
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mario_obj_scan_if.sv
// ============================================================================
//  Module      : mario_obj_scan_if
//  Description : Object RAM read port and hit-record stream of the scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mario_obj_scan_if;
  logic [8:0] ram_a;
  logic       ram_rd;
  logic [7:0] ram_d;
  logic       obj_valid;
  logic       obj_ready;
  logic [3:0] obj_row;
  logic [7:0] obj_code;
  logic [7:0] obj_attr;
  logic [7:0] obj_x;

  modport master (
    output ram_a, ram_rd, obj_valid, obj_row, obj_code, obj_attr, obj_x,
    input  ram_d, obj_ready
  );

  modport slave (
    input  ram_a, ram_rd, obj_valid, obj_row, obj_code, obj_attr, obj_x,
    output ram_d, obj_ready
  );
endinterface

`default_nettype wire

// File: rtl/mario_obj_scan.sv
// ============================================================================
//  Module      : mario_obj_scan
//  Description : Per-scanline walk of the object RAM; streams the attributes
//                of every object crossing the requested line to the renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mario_obj_scan
  import mario_pkg::*;
#(
  parameter int OBJ_COUNT = OBJ_ENTRIES,
  parameter int MAX_HITS  = 16,
  parameter int OBJ_H     = OBJ_H_DEFAULT
) (
  input  logic                   I_CLK,
  input  logic                   I_RST,
  input  logic                   I_LINE_START,
  input  logic [7:0]             I_LINE,
  input  logic                   I_DMA_BUSY,
  mario_obj_scan_if.master       bus,
  output logic                   O_BUSY,
  output logic                   O_DONE,
  output logic                   O_OVF
);

  localparam int IDX_W = 7;
  localparam int HIT_W = $clog2(MAX_HITS + 1);

  scan_state_e      state_q, state_d;
  logic [7:0]       line_q, line_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [HIT_W-1:0] hits_q, hits_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       row_q, row_d;
  logic [7:0]       code_q, code_d;
  logic [7:0]       attr_q, attr_d;
  logic [7:0]       x_q, x_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             data_ok_q, data_ok_d;
  logic             ram_rd;
  logic [1:0]       ram_off;
  obj_hit_t         hit_res;

  // Attribute bytes are requested one state ahead of their capture so the
  // record is complete on entry to EMIT and EMIT never touches the RAM.
  // data_ok_q says last cycle's read really happened; a consuming state
  // without it (the DMA took the port) re-issues its own byte first.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    index_d   = index_q;
    hits_d    = hits_q;
    ovf_d     = ovf_q;
    row_d     = row_q;
    code_d    = code_q;
    attr_d    = attr_q;
    x_d       = x_q;
    done_d    = 1'b0;
    ram_rd    = 1'b0;
    ram_off   = OFF_Y;
    hit_res   = obj_hit(line_q, bus.ram_d, 9'(OBJ_H));

    unique case (state_q)
      ST_IDLE: ;
      ST_FETCH_Y: begin
        if (!I_DMA_BUSY) begin
          ram_rd  = 1'b1;
          ram_off = OFF_Y;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!I_DMA_BUSY) begin
          if (!data_ok_q) begin
            ram_rd  = 1'b1;
            ram_off = OFF_Y;
          end else if (!hit_res.hit) begin
            state_d = ST_NEXT;
          end else if (hits_q == HIT_W'(MAX_HITS)) begin
            ovf_d   = 1'b1;
            state_d = ST_NEXT;
          end else begin
            row_d   = hit_res.row;
            ram_rd  = 1'b1;
            ram_off = OFF_CODE;
            state_d = ST_FETCH_B1;
          end
        end
      end
      ST_FETCH_B1: begin
        if (!I_DMA_BUSY) begin
          ram_rd = 1'b1;
          if (!data_ok_q) begin
            ram_off = OFF_CODE;
          end else begin
            code_d  = bus.ram_d;
            ram_off = OFF_ATTR;
            state_d = ST_FETCH_B2;
          end
        end
      end
      ST_FETCH_B2: begin
        if (!I_DMA_BUSY) begin
          ram_rd = 1'b1;
          if (!data_ok_q) begin
            ram_off = OFF_ATTR;
          end else begin
            attr_d  = bus.ram_d;
            ram_off = OFF_X;
            state_d = ST_FETCH_B3;
          end
        end
      end
      ST_FETCH_B3: begin
        if (!I_DMA_BUSY) begin
          if (!data_ok_q) begin
            ram_rd  = 1'b1;
            ram_off = OFF_X;
          end else begin
            x_d     = bus.ram_d;
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (bus.obj_ready) begin
          hits_d  = hits_q + HIT_W'(1);
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (index_q == IDX_W'(OBJ_COUNT - 1)) begin
          state_d = ST_DONE;
        end else begin
          index_d = index_q + IDX_W'(1);
          state_d = ST_FETCH_Y;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new line request wins over everything, including a pending DONE.
    if (I_LINE_START) begin
      line_d  = I_LINE;
      index_d = '0;
      hits_d  = '0;
      ovf_d   = 1'b0;
      done_d  = 1'b0;
      ram_rd  = 1'b0;
      state_d = ST_FETCH_Y;
    end

    data_ok_d = ram_rd;
    valid_d   = (state_d == ST_EMIT);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q   <= ST_IDLE;
      line_q    <= '0;
      index_q   <= '0;
      hits_q    <= '0;
      ovf_q     <= 1'b0;
      row_q     <= '0;
      code_q    <= '0;
      attr_q    <= '0;
      x_q       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      index_q   <= index_d;
      hits_q    <= hits_d;
      ovf_q     <= ovf_d;
      row_q     <= row_d;
      code_q    <= code_d;
      attr_q    <= attr_d;
      x_q       <= x_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      data_ok_q <= data_ok_d;
    end
  end

  assign bus.ram_rd    = ram_rd;
  assign bus.ram_a     = ram_rd ? {index_q, ram_off} : 9'd0;
  // An abort retracts the record in the same cycle so it cannot be accepted.
  assign bus.obj_valid = valid_q & ~I_LINE_START;
  assign bus.obj_row   = row_q;
  assign bus.obj_code  = code_q;
  assign bus.obj_attr  = attr_q;
  assign bus.obj_x     = x_q;
  assign O_BUSY        = busy_q;
  assign O_DONE        = done_q;
  assign O_OVF         = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mario_obj_scan.sv
// ============================================================================
//  Module      : tb_mario_obj_scan
//  Description : Directed scoreboard bench for the object scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mario_obj_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line_start = 1'b0;
  logic [7:0] line = 8'd0;
  logic       dma_busy = 1'b0;
  logic       o_busy, o_done, o_ovf;

  mario_obj_scan_if bus ();

  mario_obj_scan #(
    .OBJ_COUNT (96),
    .MAX_HITS  (16),
    .OBJ_H     (16)
  ) dut (
    .I_CLK        (clk),
    .I_RST        (rst),
    .I_LINE_START (line_start),
    .I_LINE       (line),
    .I_DMA_BUSY   (dma_busy),
    .bus          (bus),
    .O_BUSY       (o_busy),
    .O_DONE       (o_done),
    .O_OVF        (o_ovf)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:383];
  logic [7:0]  ram_q = 8'd0;
  int          cyc = 0;
  int          n_pass = 0, n_total = 0;
  int          done_cnt = 0, done_cyc = 0, rec_cnt = 0;
  int          d0 = 0, t0 = 0, rec0 = 0;
  logic        rd_in_busy = 1'b0, addr_bad = 1'b0;
  logic [27:0] exp_q [$];
  logic [27:0] exp_rec;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM with one-cycle read latency; the DMA owns the bus while busy.
  always @(posedge clk) begin
    if (dma_busy) ram_q <= 8'hEE;
    else if (bus.ram_rd) ram_q <= mem[bus.ram_a];
  end
  assign bus.ram_d = dma_busy ? 8'hEE : ram_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [27:0] rec_now();
    return {bus.obj_row, bus.obj_code, bus.obj_attr, bus.obj_x};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.obj_valid && bus.obj_ready) begin
        rec_cnt++;
        if (exp_q.size() == 0) begin
          chk("rec_unexpected_queue_size", exp_q.size(), 1);
        end else begin
          exp_rec = exp_q.pop_front();
          chk("record", rec_now(), exp_rec);
        end
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (dma_busy && bus.ram_rd) rd_in_busy = 1'b1;
      if (bus.ram_rd && bus.ram_a > 9'h17F) addr_bad = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 384; i++) mem[i] = 8'h00;
  endtask

  task automatic set_entry(input int idx, input logic [7:0] y, input logic [7:0] c,
                           input logic [7:0] a, input logic [7:0] x);
    mem[4*idx]   = y;
    mem[4*idx+1] = c;
    mem[4*idx+2] = a;
    mem[4*idx+3] = x;
  endtask

  task automatic start_scan(input logic [7:0] l);
    line       = l;
    line_start = 1'b1;
    d0         = done_cnt;
    rec0       = rec_cnt;
    tick();
    line_start = 1'b0;
    t0         = cyc;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input int exp_recs,
                           input logic exp_ovf);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_done_count"}, done_cnt - d0, 1);
    if (exp_lat >= 0) chk({name, "_latency"}, done_cyc - t0, exp_lat);
    chk({name, "_records"}, rec_cnt - rec0, exp_recs);
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_ovf"}, o_ovf, exp_ovf);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.obj_valid && n < 400) begin
      tick();
      n++;
    end
    chk({name, "_valid_seen"}, bus.obj_valid, 1);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_ctrl"}, {bus.obj_valid, o_busy, o_done, o_ovf, bus.ram_rd, bus.ram_a}, 0);
    chk({name, "_fields"}, rec_now(), 0);
  endtask

  initial begin
    logic [27:0] snap;
    logic        stable;

    bus.obj_ready = 1'b1;
    clear_mem();
    repeat (3) tick();
    chk_outputs_zero("reset");
    rst = 1'b0;
    tick();

    // A: single hit on entry 5
    set_entry(5, 8'h40, 8'h12, 8'h03, 8'h80);
    exp_q.push_back({4'd5, 8'h12, 8'h03, 8'h80});
    start_scan(8'h45);
    wait_done("A", 293, 1, 1'b0);

    // D: same entry, renderer stalls for 10 valid cycles
    bus.obj_ready = 1'b0;
    exp_q.push_back({4'd5, 8'h12, 8'h03, 8'h80});
    start_scan(8'h45);
    wait_valid("D");
    snap   = rec_now();
    stable = 1'b1;
    repeat (9) begin
      tick();
      if (!bus.obj_valid || rec_now() !== snap) stable = 1'b0;
    end
    tick();
    if (!bus.obj_valid || rec_now() !== snap) stable = 1'b0;
    bus.obj_ready = 1'b1;
    chk("D_stable", stable, 1);
    wait_done("D", 303, 1, 1'b0);

    // B: height boundaries, line wrap, empty slot
    clear_mem();
    set_entry(0, 8'h40, 8'hA1, 8'hA2, 8'hA3);
    start_scan(8'h3F);
    wait_done("B_3F", 289, 0, 1'b0);
    exp_q.push_back({4'hF, 8'hA1, 8'hA2, 8'hA3});
    start_scan(8'h4F);
    wait_done("B_4F", 293, 1, 1'b0);
    start_scan(8'h50);
    wait_done("B_50", 289, 0, 1'b0);
    set_entry(0, 8'hF8, 8'hB1, 8'hB2, 8'hB3);
    exp_q.push_back({4'd11, 8'hB1, 8'hB2, 8'hB3});
    start_scan(8'h03);
    wait_done("B_wrap", 293, 1, 1'b0);
    clear_mem();
    set_entry(7, 8'h00, 8'h55, 8'h66, 8'h77);
    start_scan(8'h00);
    wait_done("B_empty", 289, 0, 1'b0);

    // C: 20 hits, only 16 delivered
    clear_mem();
    for (int i = 0; i < 20; i++) begin
      set_entry(i, 8'h10, 8'(i), 8'(8'h20 + i), 8'(3 * i));
      if (i < 16) exp_q.push_back({4'd0, 8'(i), 8'(8'h20 + i), 8'(3 * i)});
    end
    start_scan(8'h10);
    wait_done("C", 353, 16, 1'b1);
    start_scan(8'h90);
    chk("C_ovf_cleared", o_ovf, 0);
    wait_done("C_next", 289, 0, 1'b0);

    // E: DMA holds the port for 50 cycles mid-fetch
    clear_mem();
    set_entry(5, 8'h40, 8'h12, 8'h03, 8'h80);
    set_entry(40, 8'h38, 8'h77, 8'h01, 8'h10);
    exp_q.push_back({4'd5, 8'h12, 8'h03, 8'h80});
    exp_q.push_back({4'd13, 8'h77, 8'h01, 8'h10});
    start_scan(8'h45);
    repeat (17) tick();
    dma_busy = 1'b1;
    repeat (50) tick();
    dma_busy = 1'b0;
    wait_done("E", -1, 2, 1'b0);
    chk("E_no_read_while_busy", rd_in_busy, 0);

    // F: abort with a new line while a record is pending
    clear_mem();
    set_entry(5, 8'h40, 8'h12, 8'h03, 8'h80);
    set_entry(10, 8'h1C, 8'h34, 8'h56, 8'h78);
    bus.obj_ready = 1'b0;
    start_scan(8'h45);
    wait_valid("F");
    line          = 8'h20;
    line_start    = 1'b1;
    bus.obj_ready = 1'b1;
    #1;
    chk("F_valid_dropped", bus.obj_valid, 0);
    exp_q.push_back({4'd4, 8'h34, 8'h56, 8'h78});
    tick();
    line_start = 1'b0;
    t0         = cyc;
    wait_done("F_abort", 293, 1, 1'b0);

    // F: synchronous reset while a record is on offer
    bus.obj_ready = 1'b0;
    start_scan(8'h45);
    wait_valid("F_rst");
    rst = 1'b1;
    tick();
    chk_outputs_zero("F_rst");
    rst           = 1'b0;
    bus.obj_ready = 1'b1;
    repeat (5) tick();
    chk("F_rst_idle", {o_busy, o_done}, 0);

    chk("addr_range", addr_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
